// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU opcode constants and small decode helpers.
// Opcodes are 4 bits; values 0 and 9..15 are undefined and ignored by the unit.
package e_mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Operations that occupy the unit for several cycles.
  function automatic logic is_long_op(logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: combinational signed/unsigned multiply and divide.
// Ports:
//   src_a       in  32  multiplicand / dividend
//   src_b       in  32  multiplier / divisor
//   op          in  4   MDU opcode
//   result      out 64  {HI, LO}: product, or {remainder, quotient}
//   div_by_zero out 1   divide opcode with a zero divisor
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quot, rem;

  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});

  // Signed divide works on magnitudes; 0x80000000 keeps its value as an unsigned magnitude,
  // which makes 0x80000000 / -1 come out as 0x80000000 rem 0 without overflow.
  assign a_neg  = (op == MDU_DIV) && src_a[31];
  assign b_neg  = (op == MDU_DIV) && src_b[31];
  assign a_mag  = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag  = b_neg ? (~src_b + 32'd1) : src_b;
  assign b_safe = (src_b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign div_by_zero = is_div_op(op) && (src_b == 32'd0);

  always_comb begin
    result = '0;
    unique case (op)
      MDU_MULT:          result = prod_s;
      MDU_MULTU:         result = prod_u;
      MDU_DIV, MDU_DIVU: result = {rem, quot};
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// Optional macro MDU_CANCEL_EN adds a cancel input that flushes a running op and blocks start.
// Ports:
//   clk, reset  clock; asynchronous active-high reset
//   start       E-stage MDU instruction this cycle (one-cycle pulse)
//   mdu_op      opcode (see e_mdu_pkg)
//   SrcA, SrcB  rs / rt operands
//   cancel      (MDU_CANCEL_EN only) exception/interrupt flush
//   busy        long operation in progress (registered)
//   HI, LO      architectural HI/LO registers
//   MDUresult   HI for mfhi, LO for mflo, else 0 (combinational)
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_dbz_q, pend_dbz_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       arith_res;
  logic              arith_dbz;
  logic              flush;

`ifdef MDU_CANCEL_EN
  assign flush = cancel;
`else
  assign flush = 1'b0;
`endif

  e_mdu_arith u_arith (
    .src_a       (SrcA),
    .src_b       (SrcB),
    .op          (mdu_op),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (is_long_op(mdu_op)) begin
            pend_hi_d  = arith_res[63:32];
            pend_lo_d  = arith_res[31:0];
            pend_dbz_d = arith_dbz;
            cnt_d      = is_div_op(mdu_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d    = StRun;
          end else if (mdu_op == MDU_MTHI) begin
            hi_d = SrcA;
          end else if (mdu_op == MDU_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      StRun: begin
        // Starts arriving here are ignored; flush wins over the final commit.
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            if (!pend_dbz_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign MDUresult = (mdu_op == MDU_MFHI) ? hi_q :
                     (mdu_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against a behavioural HI/LO model.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] SrcA, SrcB;
  logic        busy;
  logic [31:0] HI, LO, MDUresult;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
`ifdef MDU_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy),
    .HI        (HI),
    .LO        (LO),
    .MDUresult (MDUresult)
  );

  // Architectural effect of one accepted instruction on HI/LO.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MDU_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      MDU_MULTU: begin up = 64'(a) * 64'(b); hi = up[63:32]; lo = up[31:0]; end
      MDU_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      MDU_DIVU:  if (b != 0) begin lo = a / b; hi = a % b; end
      MDU_MTHI:  hi = a;
      MDU_MTLO:  lo = a;
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return MultN;
    if (op == MDU_DIV || op == MDU_DIVU) return DivN;
    return 0;
  endfunction

  // Called and returns 1 time unit after a rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0; SrcA = $urandom; SrcB = $urandom;
  endtask

  // Counts busy cycles (bounded); returns 1 unit after the edge following the first idle cycle.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    issue(op, a, b);
    count_busy(nb);
    model(op, a, b, hi_m, lo_m);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mdu_op = MDU_MFHI; SrcA = '0; SrcB = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    hi_m = '0; lo_m = '0;
    #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
    n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
    n_checks++;
    if (MDUresult !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi got %h want 0", MDUresult); end
    @(negedge clk); reset = 1'b0; mdu_op = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int nb;
    do_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, nb);
    n_checks++; if (nb !== MultN) begin n_fail++; $display("FAIL mult_busy got %0d want %0d", nb, MultN); end
    n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    n_checks++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", LO); end
    mdu_op = MDU_MFHI; #1;
    n_checks++;
    if (MDUresult !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL mfhi got %h want ffffffff", MDUresult);
    end
    @(posedge clk); #1; mdu_op = 4'd0;
    do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    n_checks++; if (nb !== MultN) begin n_fail++; $display("FAIL multu_busy got %0d want %0d", nb, MultN); end
    n_checks++; if (HI !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", HI); end
    n_checks++; if (LO !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 1", LO); end
  endtask

  task automatic test_div();
    int nb;
    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, nb);
    n_checks++; if (nb !== DivN) begin n_fail++; $display("FAIL div_busy got %0d want %0d", nb, DivN); end
    n_checks++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", LO); end
    n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", HI); end
    do_op(MDU_DIVU, 32'd7, 32'd2, nb);
    n_checks++; if (LO !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", LO); end
    n_checks++; if (HI !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", HI); end
    do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
    n_checks++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lo got %h want 80000000", LO); end
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL ovf_hi got %h want 0", HI); end
  endtask

  task automatic test_div_zero();
    int nb;
    do_op(MDU_MTHI, 32'h1234, 32'd0, nb);
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL mthi_busy got %0d want 0", nb); end
    do_op(MDU_MTLO, 32'h5678, 32'd0, nb);
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL mtlo_busy got %0d want 0", nb); end
    do_op(MDU_DIV, 32'd5, 32'd0, nb);
    n_checks++; if (nb !== DivN) begin n_fail++; $display("FAIL dz_busy got %0d want %0d", nb, DivN); end
    n_checks++; if (HI !== 32'h1234) begin n_fail++; $display("FAIL dz_hi got %h want 1234", HI); end
    n_checks++; if (LO !== 32'h5678) begin n_fail++; $display("FAIL dz_lo got %h want 5678", LO); end
  endtask

  task automatic test_undefined_op();
    int nb;
    logic [3:0] op;
    for (int i = 0; i < 4; i++) begin
      op = (i == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      do_op(op, $urandom, $urandom, nb);
      n_checks++;
      if (nb !== 0 || HI !== hi_m || LO !== lo_m) begin
        n_fail++;
        $display("FAIL undef_op op=%0d got busy=%0d hi=%h lo=%h want 0 %h %h",
                 op, nb, HI, LO, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_start_in_run();
    int nb;
    // mtlo during RUN is dropped, then reset in cycle 3 abandons the multiply.
    issue(MDU_MULT, 32'd6, 32'd7);
    @(posedge clk); #1;
    start = 1'b1; mdu_op = MDU_MTLO; SrcA = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    #2 reset = 1'b1; #1;
    hi_m = '0; lo_m = '0;
    n_checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL run_reset got busy=%b hi=%h lo=%h want 0 0 0", busy, HI, LO);
    end
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL no_commit got busy=%b hi=%h lo=%h want 0 0 0", busy, HI, LO);
    end
    issue(MDU_MULT, 32'd6, 32'd7);
    @(posedge clk); #1;
    start = 1'b1; mdu_op = MDU_MTLO; SrcA = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    count_busy(nb);
    model(MDU_MULT, 32'd6, 32'd7, hi_m, lo_m);
    n_checks++;
    if (nb !== MultN - 2) begin n_fail++; $display("FAIL run_busy got %0d want %0d", nb, MultN - 2); end
    n_checks++;
    if (LO !== 32'd42 || HI !== 32'd0) begin
      n_fail++; $display("FAIL run_commit got hi=%h lo=%h want 0 2a", HI, LO);
    end
  endtask

  task automatic test_random();
    int nb;
    logic [3:0]  op;
    logic [31:0] a, b, want;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      mdu_op = op; #1;
      want = (op == MDU_MFHI) ? hi_m : (op == MDU_MFLO) ? lo_m : 32'd0;
      n_checks++;
      if (MDUresult !== want) begin
        n_fail++; $display("FAIL rnd_result op=%0d got %h want %h", op, MDUresult, want);
      end
      @(posedge clk); #1;
      do_op(op, a, b, nb);
      n_checks++;
      if (nb !== latency(op) || HI !== hi_m || LO !== lo_m) begin
        n_fail++;
        $display("FAIL rnd_op op=%0d a=%h b=%h got busy=%0d hi=%h lo=%h want %0d %h %h",
                 op, a, b, nb, HI, LO, latency(op), hi_m, lo_m);
      end
    end
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    int nb;
    issue(MDU_DIV, 32'd100, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
      n_fail++; $display("FAIL cancel_run got busy=%b hi=%h lo=%h want 0 %h %h",
                         busy, HI, LO, hi_m, lo_m);
    end
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (HI !== hi_m || LO !== lo_m) begin
      n_fail++; $display("FAIL cancel_late got hi=%h lo=%h want %h %h", HI, LO, hi_m, lo_m);
    end
    cancel = 1'b1;
    issue(MDU_MTHI, 32'hDEAD, 32'd0);
    issue(MDU_MULT, 32'd3, 32'd3);
    cancel = 1'b0;
    count_busy(nb);
    n_checks++;
    if (nb !== 0 || HI !== hi_m || LO !== lo_m) begin
      n_fail++; $display("FAIL cancel_idle got busy=%0d hi=%h lo=%h want 0 %h %h",
                         nb, HI, LO, hi_m, lo_m);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_undefined_op();
    test_start_in_run();
    test_random();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
